// File: rtl/sum16_kpg_adder.sv
// sum16_kpg_adder: registered 16-bit adder with a Kogge-Stone KPG carry network and a KPG-encoded carry-in
module sum16_kpg_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  kIn,
  output logic [16:0] sum
);
  // symbols: k=00, p=01, g=11; index 0 holds the carry-in, index i+1 holds bit i
  logic [1:0] s [0:5][0:16];
  logic [16:0] c;
  logic [16:0] nxt;
  function automatic logic [1:0] kpg(input logic [1:0] x, input logic [1:0] y);
    return (x == 2'b00) ? 2'b00 : (x == 2'b11) ? 2'b11 : y;
  endfunction
  // a propagate carry-in has nothing below it, so it resolves to kill
  assign s[0][0] = (kIn == 2'b11) ? 2'b11 : 2'b00;
  for (genvar j = 0; j < 16; j++) begin : g_sym
    assign s[0][j+1] = {a[j] & b[j], a[j] | b[j]};
  end
  for (genvar l = 0; l < 5; l++) begin : g_lvl
    for (genvar j = 0; j < 17; j++) begin : g_pos
      if (j >= (1 << l)) begin : g_cmb
        assign s[l+1][j] = kpg(s[l][j], s[l][j-(1<<l)]);
      end else begin : g_pass
        assign s[l+1][j] = s[l][j];
      end
    end
  end
  for (genvar j = 0; j < 17; j++) begin : g_car
    assign c[j] = s[5][j][1];
  end
  assign nxt = {c[16], a ^ b ^ c[15:0]};
  always_ff @(posedge clk) begin
    if (rst) sum <= 17'h0;
    else sum <= nxt;
  end
endmodule

// File: tb/tb_sum16_kpg_adder.sv
// tb_sum16_kpg_adder: directed and random checks of the registered KPG adder against an arithmetic model
module tb_sum16_kpg_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [1:0]  kIn = '0;
  logic [16:0] sum;
  logic [16:0] exp_sum = '0;
  logic        valid = 1'b0;
  logic        done = 1'b0;
  int checks = 0;
  int errors = 0;

  sum16_kpg_adder dut (.clk(clk), .rst(rst), .a(a), .b(b), .kIn(kIn), .sum(sum));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // reference: plain integer addition; only kIn==11 is a carry
  always @(posedge clk) begin
    exp_sum <= rst ? 17'h0 : 17'(a) + 17'(b) + 17'(kIn == 2'b11);
    valid <= 1'b1;
  end

  always @(negedge clk)
    if (valid && !done) chk("model", sum, exp_sum);

  task automatic step(input logic r, input logic [15:0] ta, input logic [15:0] tb,
                      input logic [1:0] tk, input string name, input logic [16:0] want);
    rst = r; a = ta; b = tb; kIn = tk;
    @(posedge clk);
    #1 chk(name, sum, want);
  endtask

  initial begin
    step(1'b1, 16'hFFFF, 16'hFFFF, 2'b11, "reset", 17'h00000);
    step(1'b0, 16'hFFFF, 16'hFFFF, 2'b11, "release_max", 17'h1FFFF);
    step(1'b0, 16'h9999, 16'hFFFF, 2'b00, "basic1", 17'h19998);
    step(1'b0, 16'h999A, 16'h0000, 2'b00, "basic2", 17'h0999A);
    step(1'b0, 16'hFFFF, 16'h0000, 2'b11, "cin_ripple", 17'h10000);
    step(1'b0, 16'h0000, 16'h0000, 2'b01, "prop01", 17'h00000);
    step(1'b0, 16'h0000, 16'h0000, 2'b10, "prop10", 17'h00000);
    step(1'b0, 16'h0000, 16'h0000, 2'b11, "zero_cin", 17'h00001);
    step(1'b0, 16'h8000, 16'h8000, 2'b10, "msb_carry", 17'h10000);
    step(1'b0, 16'h1234, 16'h4321, 2'b11, "mixed", 17'h05556);
    step(1'b0, 16'hFFFF, 16'hFFFF, 2'b01, "max_prop", 17'h1FFFE);
    step(1'b1, 16'h1234, 16'h4321, 2'b11, "reset_mid", 17'h00000);
    for (int i = 0; i < 20; i++) begin
      logic [15:0] sa, sb;
      sa = 16'h9999 + 16'(i);
      sb = 16'hFFFF + 16'(i);
      step(1'b0, sa, sb, 2'b00, "stream", 17'(sa) + 17'(sb));
    end
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      kIn = 2'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
